// File: rtl/sr_bank_arbiter_pkg.sv
// Shared types and constants for the SR latch bank arbiter.
package sr_bank_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnable,
    StHold,
    StCheck
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/sr_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic last_q;

  always_comb begin
    gnt_vld_o = |req_i;
    // On contention the requester not granted last wins.
    gnt_idx_o = (req_i == 2'b11) ? ~last_q : req_i[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd_i && gnt_vld_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Shares a bank of gated SR latches between two requesters, sequencing each
// write through setup/enable/hold and checking the readback.
module sr_bank_arbiter
  import sr_bank_arbiter_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned IDXW      = 2,
  parameter int unsigned EN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic            op0,
  input  logic [IDXW-1:0] idx0,
  input  logic            op1,
  input  logic [IDXW-1:0] idx1,
  output logic [1:0]      done,
  output logic            err,
  output logic            busy,
  output logic [N-1:0]    S,
  output logic [N-1:0]    R,
  output logic [N-1:0]    E,
  input  logic [N-1:0]    Q
);

  localparam int unsigned   CntW    = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(EN_CYCLES - 1);

  state_e          state_q, state_d;
  logic            win_q, win_d;
  logic            op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    sel_q, sel_d;
  logic [N-1:0]    s_q, s_d, r_q, r_d, e_q, e_d;
  logic [1:0]      done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q;

  logic            gnt_vld, gnt_idx, arb_upd;
  logic            op_req;
  logic [IDXW-1:0] idx_req;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .upd_i     (arb_upd),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign arb_upd = (state_q == StIdle);
  assign op_req  = gnt_idx ? op1 : op0;
  assign idx_req = gnt_idx ? idx1 : idx0;
  assign sel_q   = N'(1) << idx_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          win_d = gnt_idx;
          op_d  = op_req;
          idx_d = idx_req;
          // Out-of-range cells are reported without touching the bank.
          if (32'(idx_req) >= N) begin
            state_d = StCheck;
            err_d   = 1'b1;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        state_d = StEnable;
        cnt_d   = '0;
      end
      StEnable: begin
        if (cnt_q == CntLast) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        state_d = StCheck;
        // Q has settled since E dropped; the result is registered into CHECK.
        err_d   = ((Q & sel_q) != '0) != op_q;
      end
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    sel_d  = N'(1) << idx_d;
    s_d    = '0;
    r_d    = '0;
    e_d    = '0;
    done_d = '0;
    if (state_d inside {StSetup, StEnable, StHold}) begin
      s_d = (op_d == OP_SET) ? sel_d : '0;
      r_d = (op_d == OP_SET) ? '0 : sel_d;
    end
    if (state_d == StEnable) begin
      e_d = sel_d;
    end
    if (state_d == StCheck) begin
      done_d = win_d ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      e_q     <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      e_q     <= e_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign S    = s_q;
  assign R    = r_q;
  assign E    = e_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench: latch bank model, arbitration/cell reference model, random sweep.
module tb_sr_bank_arbiter;

  localparam int unsigned N         = 4;
  localparam int unsigned IDXW      = 2;
  localparam int unsigned EN_CYCLES = 2;
  localparam int          Lat       = EN_CYCLES + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req = '0;
  logic            op0 = 1'b0, op1 = 1'b0;
  logic [IDXW-1:0] idx0 = '0, idx1 = '0;
  logic [1:0]      done;
  logic            err, busy;
  logic [N-1:0]    S, R, E, Q;
  logic [N-1:0]    q_lat = '0;
  logic [N-1:0]    force_mask = '0;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;
  int done_cnt = 0;
  int grant_cnt = 0;

  bit model_cell [N];
  int model_last = 1;

  always #5 clk = ~clk;

  sr_bank_arbiter #(.N(N), .IDXW(IDXW), .EN_CYCLES(EN_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .op0   (op0),
    .idx0  (idx0),
    .op1   (op1),
    .idx1  (idx1),
    .done  (done),
    .err   (err),
    .busy  (busy),
    .S     (S),
    .R     (R),
    .E     (E),
    .Q     (Q)
  );

  // Gated SR latch bank: transparent while E is high.
  always @(E, S, R) begin
    for (int i = 0; i < N; i++) begin
      if (E[i] && S[i]) q_lat[i] = 1'b1;
      else if (E[i] && R[i]) q_lat[i] = 1'b0;
    end
  end
  assign Q = q_lat & ~force_mask;

  always @(negedge clk) begin
    if (inv_en && rst_n) begin
      checks++;
      if ((S & R) != '0 || $countones(E) > 1 || (E & ~(S | R)) != '0 ||
          $countones(S | R) > 1 || (!busy && (S | R | E) != '0) ||
          (done != '0 && !busy) || $countones(done) > 1 || (err && done == '0)) begin
        errors++;
        $display("FAIL invariant t=%0t: S=%b R=%b E=%b busy=%b done=%b err=%b",
                 $time, S, R, E, busy, done, err);
      end
      done_cnt += $countones(done);
    end
  end

  function automatic logic [N-1:0] model_q();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = model_cell[i];
    return v;
  endfunction

  // Reference: decide the winner from the round-robin rule and apply its write.
  function automatic logic [1:0] model_grant(input logic [1:0] r);
    int win;
    if (r == 2'b11) win = (model_last == 1) ? 0 : 1;
    else win = r[1] ? 1 : 0;
    model_last = win;
    grant_cnt++;
    if (win == 1) model_cell[idx1] = op1;
    else model_cell[idx0] = op0;
    return (win == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic run_req(input logic [1:0] r, output int lat, output logic [1:0] d,
                         output logic e, output logic [N-1:0] s_or, output logic [N-1:0] r_or,
                         output logic [N-1:0] e_or, output int s_cyc, output int e_cyc);
    lat = 0; d = '0; e = 1'b0; s_or = '0; r_or = '0; e_or = '0; s_cyc = 0; e_cyc = 0;
    @(negedge clk);
    req = r;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      s_or |= S; r_or |= R; e_or |= E;
      if ((S | R) != '0) s_cyc++;
      if (E != '0) e_cyc++;
      if (done != '0) begin
        d = done;
        e = err;
        break;
      end
    end
    req = '0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({S, R, E, done, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got S=%b R=%b E=%b done=%b err=%b busy=%b want all 0",
               S, R, E, done, err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    inv_en = 1'b1;
  endtask

  task automatic test_single_set();
    int lat, sc, ec; logic [1:0] d, dx; logic e; logic [N-1:0] so, ro, eo;
    op0 = 1'b1; idx0 = 2'd2;
    dx = model_grant(2'b01);
    run_req(2'b01, lat, d, e, so, ro, eo, sc, ec);
    checks++;
    if (d !== dx || e !== 1'b0 || lat != Lat) begin
      errors++;
      $display("FAIL single_done: got done=%b err=%b lat=%0d want done=%b err=0 lat=%0d",
               d, e, lat, dx, Lat);
    end
    checks++;
    if (so !== 4'b0100 || ro !== '0 || sc != EN_CYCLES + 2) begin
      errors++;
      $display("FAIL single_sr: got S|=%b R|=%b cycles=%0d want 0100 0000 %0d",
               so, ro, sc, EN_CYCLES + 2);
    end
    checks++;
    if (eo !== 4'b0100 || ec != EN_CYCLES) begin
      errors++;
      $display("FAIL single_e: got E|=%b cycles=%0d want 0100 %0d", eo, ec, EN_CYCLES);
    end
    checks++;
    if (Q !== model_q()) begin
      errors++;
      $display("FAIL single_q: got Q=%b want %b", Q, model_q());
    end
  endtask

  task automatic test_hold();
    int lat, sc, ec, bad; logic [1:0] d, dx; logic e; logic [N-1:0] so, ro, eo;
    op0 = 1'b1; idx0 = 2'd1;
    dx = model_grant(2'b01);
    run_req(2'b01, lat, d, e, so, ro, eo, sc, ec);
    checks++;
    if (d !== dx || Q[1] !== 1'b1) begin
      errors++;
      $display("FAIL hold_set: got done=%b Q1=%b want done=%b Q1=1", d, Q[1], dx);
    end
    op1 = 1'b0; idx1 = 2'd1;
    dx = model_grant(2'b10);
    run_req(2'b10, lat, d, e, so, ro, eo, sc, ec);
    checks++;
    if (d !== dx || ro !== 4'b0010 || so !== '0 || sc != EN_CYCLES + 2 || Q !== model_q()) begin
      errors++;
      $display("FAIL hold_reset: got done=%b R|=%b S|=%b cyc=%0d Q=%b want %b 0010 0000 %0d %b",
               d, ro, so, sc, Q, dx, EN_CYCLES + 2, model_q());
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Q[1] !== 1'b0 || E !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_idle: got %0d bad idle cycles want 0", bad);
    end
  endtask

  task automatic test_contention();
    int gap, prev; logic [1:0] dx;
    op0 = 1'b1; idx0 = 2'd0; op1 = 1'b0; idx1 = 2'd3;
    prev = -1;
    gap = 0;
    @(negedge clk);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      while (gap < 40) begin
        @(posedge clk);
        gap++;
        @(negedge clk);
        if (done != '0) break;
      end
      dx = model_grant(2'b11);
      checks++;
      if (done !== dx || err !== 1'b0) begin
        errors++;
        $display("FAIL contention_%0d: got done=%b err=%b want done=%b err=0", k, done, err, dx);
      end
      if (prev >= 0) begin
        checks++;
        if (gap != Lat + 1) begin
          errors++;
          $display("FAIL contention_gap_%0d: got %0d cycles want %0d", k, gap, Lat + 1);
        end
      end
      prev = k;
    end
    req = '0;
    checks++;
    if (Q !== model_q()) begin
      errors++;
      $display("FAIL contention_q: got Q=%b want %b", Q, model_q());
    end
  endtask

  task automatic test_readback_err();
    int lat, sc, ec, bad; logic [1:0] d, dx; logic e; logic [N-1:0] so, ro, eo;
    force_mask = 4'b1000;
    op0 = 1'b1; idx0 = 2'd3;
    dx = model_grant(2'b01);
    run_req(2'b01, lat, d, e, so, ro, eo, sc, ec);
    checks++;
    if (d !== dx || e !== 1'b1) begin
      errors++;
      $display("FAIL readback_err: got done=%b err=%b want done=%b err=1", d, e, dx);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL readback_noretry: got busy in %0d cycles want 0", bad);
    end
    force_mask = '0;
  endtask

  task automatic test_reset_mid();
    int w, lat, sc, ec; logic [1:0] d, dx; logic e; logic [N-1:0] so, ro, eo;
    op0 = 1'b0; idx0 = 2'd1;
    @(negedge clk);
    req = 2'b01;
    w = 0;
    while (E == '0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (E !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_enable: got E=%b want 0010", E);
    end
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({S, R, E, done, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got S=%b R=%b E=%b done=%b busy=%b want all 0",
               S, R, E, done, busy);
    end
    model_cell[1] = 1'b0;
    model_last = 1;
    @(negedge clk);
    rst_n = 1'b1;
    op0 = 1'b1; idx0 = 2'd2; op1 = 1'b1; idx1 = 2'd0;
    dx = model_grant(2'b11);
    run_req(2'b11, lat, d, e, so, ro, eo, sc, ec);
    checks++;
    if (d !== dx || d !== 2'b01 || lat != Lat) begin
      errors++;
      $display("FAIL midreset_regrant: got done=%b lat=%0d want 01 lat=%0d", d, lat, Lat);
    end
  endtask

  task automatic test_random();
    int lat, sc, ec, bad; logic [1:0] r, d, dx; logic e; logic [N-1:0] so, ro, eo;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      r = 2'($urandom_range(3, 1));
      op0 = 1'($urandom); op1 = 1'($urandom);
      idx0 = IDXW'($urandom_range(N - 1)); idx1 = IDXW'($urandom_range(N - 1));
      dx = model_grant(r);
      run_req(r, lat, d, e, so, ro, eo, sc, ec);
      checks++;
      if (d !== dx || e !== 1'b0 || lat != Lat || Q !== model_q() || ec != EN_CYCLES) begin
        errors++;
        if (bad < 5) begin
          $display("FAIL random_%0d: req=%b got done=%b err=%b lat=%0d Q=%b en=%0d want %b 0 %0d %b %0d",
                   k, r, d, e, lat, Q, ec, dx, Lat, model_q(), EN_CYCLES);
        end
        bad++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) model_cell[i] = 1'b0;
    test_reset();
    test_single_set();
    test_hold();
    test_contention();
    test_readback_err();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != grant_cnt) begin
      errors++;
      $display("FAIL done_count: got %0d done pulses want %0d grants", done_cnt, grant_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
